flit_demux_ctrl: RTL
====================

FLIT_DEMUX_CTRL -- requirements
Module: flit_demux_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: flit payload width in bits.
REQ-002 SHALL have parameter OUTPUT_NUM, default 2: number of output ports; legal range 2..16.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(OUTPUT_NUM): destination/select width.
REQ-004 SHALL have parameter DROP_CNT_WIDTH, default 8: width of the drop counter.
REQ-005 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-007 in_data_i  input  DATA_WIDTH  input flit payload.
REQ-008 in_dest_i  input  ADDR_WIDTH  destination port; sampled on head flit only.
REQ-009 in_last_i  input  1  flit is the packet tail (single-flit packet: head and tail together).
REQ-010 in_valid_i / in_ready_o  input / output  1 each  input handshake; transfer when both high.
REQ-011 out_data_o  output  DATA_WIDTH x OUTPUT_NUM (unpacked array)  per-port payload.
REQ-012 out_last_o  output  OUTPUT_NUM  per-port tail flag.
REQ-013 out_valid_o / out_ready_i  output / input  OUTPUT_NUM each  per-port handshake.
REQ-014 busy_o  output  1  high while a packet is open (state FWD or DROP).
REQ-015 drop_cnt_o  output  DROP_CNT_WIDTH  saturating count of dropped packets.

Function
REQ-016 SHALL implement states IDLE, FWD, DROP.
REQ-017 IDLE: head flit accepted with in_dest_i < OUTPUT_NUM SHALL latch dest into sel_q and go to FWD; with in_dest_i >= OUTPUT_NUM SHALL latch nothing and go to DROP.
REQ-018 A head flit with in_last_i=1 SHALL be forwarded or dropped and the state SHALL remain IDLE.
REQ-019 FWD/DROP: in_dest_i SHALL be ignored; the accepted flit with in_last_i=1 SHALL return the state to IDLE.
REQ-020 Forwarded flits SHALL pass through a one-entry output register (full_q, data_q, last_q); latency in-accept to out_valid_o = 1 cycle.
REQ-021 out_valid_o[i] SHALL equal full_q && (out_sel_q == i); all other ports SHALL have out_valid_o=0, out_data_o=0, out_last_o=0.
REQ-022 Output register select (out_sel_q) SHALL be loaded with the flit's destination on every forwarded accept.
REQ-023 in_ready_o SHALL equal 1 in DROP; otherwise !full_q || out_ready_i[out_sel_q] (combinational pass-through allowed, full throughput 1 flit/cycle).
REQ-024 Simultaneous out-accept and in-accept SHALL replace the register contents; full_q stays 1.
REQ-025 Dropped flits SHALL never load the output register or assert any out_valid_o.
REQ-026 drop_cnt_o SHALL increment by 1 on each dropped head flit and SHALL saturate at all-ones.
REQ-027 Once out_valid_o[i] is high, out_data_o[i]/out_last_o[i] SHALL hold stable until out_ready_i[i]=1.
REQ-028 A new packet's head SHALL be accepted in the cycle after the previous tail accept at the earliest (same cycle as IDLE entry is not required).

Reset
REQ-029 On rst_n_i=0 (any time, mid-packet included): state=IDLE, full_q=0, sel_q=0, out_sel_q=0, drop_cnt_o=0; all out_valid_o=0, busy_o=0; any partial packet SHALL be discarded.
REQ-030 in_ready_o SHALL be 0 while rst_n_i=0 and 1 in the first cycle after release.

Structure
REQ-031 The state enum (IDLE/FWD/DROP) SHALL live in the shared noc_pkg package.
REQ-032 Per-port data fan-out SHALL instantiate the existing demux primitive (DATA_WIDTH, OUTPUT_NUM) driven by data_q and out_sel_q, gated by full_q.
REQ-033 Target size 120-400 lines of RTL; no other sub-modules.

Verification
REQ-034 OUTPUT_NUM=4: 3-flit packet dest=2, all ready=1 -> flits on port 2 in cycles 1,2,3 after first accept, last on third, ports 0/1/3 valid=0.
REQ-035 Backpressure: port 1 ready=0 for 5 cycles during 4-flit packet -> in_ready_o=0 while full, no flit lost or duplicated, order preserved.
REQ-036 OUTPUT_NUM=3, head dest=3, 2-flit packet -> no out_valid_o, drop_cnt_o 0->1, next packet dest=0 delivered normally.
REQ-037 Mid-packet dest change: head dest=0, body flits with in_dest_i=1 -> all flits on port 0.
REQ-038 Assert rst_n_i mid-packet (full_q=1) -> outputs zero asynchronously, after release new packet dest=1 routes correctly; DROP_CNT_WIDTH=2 with 5 bad packets -> drop_cnt_o=3.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet-flow states used by routing/demux controllers.
package noc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } flow_state_e;

endpackage

// File: rtl/flit_demux_ctrl_demux.sv
// Demux primitive: routes one payload word to the selected port, zero elsewhere.
module flit_demux_ctrl_demux #(
    parameter int DATA_WIDTH = 32,
    parameter int OUTPUT_NUM = 2,
    parameter int SEL_WIDTH  = $clog2(OUTPUT_NUM)
) (
    input  logic                  en,
    input  logic [SEL_WIDTH-1:0]  sel,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out [OUTPUT_NUM]
);

    always_comb begin
        for (int i = 0; i < OUTPUT_NUM; i++) begin
            data_out[i] = '0;
            if (en && (sel == SEL_WIDTH'(i))) begin
                data_out[i] = data_in;
            end
        end
    end

endmodule

// File: rtl/flit_demux_ctrl.sv
// Packet-level flit demultiplexer: routes each packet to the port named by its head
// flit through a one-entry output register; packets with an illegal port are dropped.
module flit_demux_ctrl
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int OUTPUT_NUM     = 2,
    parameter int ADDR_WIDTH     = $clog2(OUTPUT_NUM),
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [DATA_WIDTH-1:0]     in_data_i,
    input  logic [ADDR_WIDTH-1:0]     in_dest_i,
    input  logic                      in_last_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [DATA_WIDTH-1:0]     out_data_o [OUTPUT_NUM],
    output logic [OUTPUT_NUM-1:0]     out_last_o,
    output logic [OUTPUT_NUM-1:0]     out_valid_o,
    input  logic [OUTPUT_NUM-1:0]     out_ready_i,
    output logic                      busy_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

    localparam logic [ADDR_WIDTH:0] PORT_LIMIT = (ADDR_WIDTH + 1)'(OUTPUT_NUM);

    flow_state_e               state_q;
    flow_state_e               state_d;
    logic [ADDR_WIDTH-1:0]     sel_q;
    logic [ADDR_WIDTH-1:0]     out_sel_q;
    logic [ADDR_WIDTH-1:0]     fwd_dest;
    logic                      full_q;
    logic                      last_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;
    logic                      accept;
    logic                      dest_ok;
    logic                      fwd_accept;
    logic                      drop_head;
    logic                      out_fire;

    assign dest_ok  = {1'b0, in_dest_i} < PORT_LIMIT;
    assign out_fire = full_q && out_ready_i[out_sel_q];

    // Dropped flits never touch the output register, so DROP can always sink input.
    assign in_ready_o = rst_n_i && ((state_q == DROP) || !full_q || out_ready_i[out_sel_q]);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d    = state_q;
        fwd_accept = 1'b0;
        drop_head  = 1'b0;
        fwd_dest   = sel_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    fwd_dest = in_dest_i;
                    if (dest_ok) begin
                        fwd_accept = 1'b1;
                        if (!in_last_i) state_d = FWD;
                    end else begin
                        drop_head = 1'b1;
                        if (!in_last_i) state_d = DROP;
                    end
                end
            end
            FWD: begin
                if (accept) begin
                    fwd_accept = 1'b1;
                    if (in_last_i) state_d = IDLE;
                end
            end
            DROP: begin
                if (accept && in_last_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && accept && dest_ok) begin
                sel_q <= in_dest_i;
            end
            if (drop_head && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + DROP_CNT_WIDTH'(1);
            end
        end
    end

    // A new forwarded flit overwrites the register even when the old one leaves this cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            full_q    <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            out_sel_q <= '0;
        end else if (fwd_accept) begin
            full_q    <= 1'b1;
            data_q    <= in_data_i;
            last_q    <= in_last_i;
            out_sel_q <= fwd_dest;
        end else if (out_fire) begin
            full_q <= 1'b0;
        end
    end

    flit_demux_ctrl_demux #(
        .DATA_WIDTH(DATA_WIDTH),
        .OUTPUT_NUM(OUTPUT_NUM),
        .SEL_WIDTH (ADDR_WIDTH)
    ) u_demux (
        .en      (full_q),
        .sel     (out_sel_q),
        .data_in (data_q),
        .data_out(out_data_o)
    );

    always_comb begin
        out_valid_o = '0;
        out_last_o  = '0;
        for (int i = 0; i < OUTPUT_NUM; i++) begin
            if (full_q && (out_sel_q == ADDR_WIDTH'(i))) begin
                out_valid_o[i] = 1'b1;
                out_last_o[i]  = last_q;
            end
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign drop_cnt_o = drop_cnt_q;

endmodule
